// File: rtl/df_pkg.sv
// Shared defaults, index-width helper and the in-flight tag type for the operator arbiter.
// Pure declarations: no latency, no flow control.
// Tag index is sized for the largest supported channel count (8).
package df_pkg;

    localparam int DEF_N      = 16;
    localparam int DEF_NCH    = 4;
    localparam int DEF_OP_LAT = 1;
    localparam int TAG_IW     = 3;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic              vld;
        logic [TAG_IW-1:0] idx;
    } tag_t;

endpackage

// File: rtl/df_rr_arbiter.sv
// Round-robin pick of the first requesting channel at or above ptr, wrapping.
// Latency: combinational. No backpressure; the caller decides whether the pick is used.
// A fixed-count loop keeps the priority rotation free of variable shifts.
module df_rr_arbiter
    import df_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           gnt_vld,
    output logic [IW-1:0]  gnt_idx
);

    always_comb begin
        int c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = 0;
        for (int i = 0; i < NCH; i++) begin
            c = (int'(ptr) + i) % NCH;
            if (!gnt_vld && req[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/df_op_arbiter.sv
// Shares one two-input operator among NCH channels; each channel buffers one operand per input.
// Latency: grant is combinational, result lands on R_OUT OP_LAT+1 cycles after the grant.
// No backpressure: tokens hitting an occupied slot are dropped (flagged on OVF with DF_OP_ARBITER_OVF_EN).
module df_op_arbiter
    import df_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int NCH    = DEF_NCH,
    parameter int OP_LAT = DEF_OP_LAT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [NCH-1:0]   R_IN1,
    input  logic [NCH-1:0]   R_IN2,
    input  logic [NCH*N-1:0] D_IN1,
    input  logic [NCH*N-1:0] D_IN2,
    output logic [NCH-1:0]   BUSY,
    output logic             OP_R_OUT1,
    output logic             OP_R_OUT2,
    output logic [N-1:0]     OP_D_OUT1,
    output logic [N-1:0]     OP_D_OUT2,
    input  logic             OP_R_IN,
    input  logic [N-1:0]     OP_D_IN,
    output logic             OP_EN,
    output logic [NCH-1:0]   R_OUT,
    output logic [NCH*N-1:0] D_OUT,
    output logic [NCH-1:0]   OVF
);

    localparam int IW = idx_w(NCH);

    logic [NCH-1:0]   v1_q, v2_q;
    logic [NCH*N-1:0] s1_q, s2_q;
    logic [IW-1:0]    ptr_q;
    logic             gnt_vld;
    logic [IW-1:0]    gnt_idx;
    logic             grant;
    logic [NCH-1:0]   gnt_oh;
    logic [NCH-1:0]   cap1, cap2;
    tag_t             pipe_q [OP_LAT];
    tag_t             tail;
    logic [NCH-1:0]   r_out_q;
    logic [NCH*N-1:0] d_out_q;

    df_rr_arbiter #(.NCH(NCH), .IW(IW)) u_rr (
        .req     (v1_q & v2_q),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign grant = EN & gnt_vld;

    always_comb begin
        gnt_oh = '0;
        if (grant) gnt_oh[gnt_idx] = 1'b1;
    end

    // A slot being drained this cycle may be refilled in the same cycle.
    assign cap1 = R_IN1 & (~v1_q | gnt_oh);
    assign cap2 = R_IN2 & (~v2_q | gnt_oh);

    assign OP_R_OUT1 = grant;
    assign OP_R_OUT2 = grant;
    assign OP_D_OUT1 = grant ? s1_q[gnt_idx*N +: N] : '0;
    assign OP_D_OUT2 = grant ? s2_q[gnt_idx*N +: N] : '0;
    assign OP_EN     = EN;
    assign BUSY      = v1_q | v2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q  <= '0;
            v2_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            ptr_q <= '0;
        end else if (EN) begin
            for (int c = 0; c < NCH; c++) begin
                if (cap1[c]) begin
                    v1_q[c]         <= 1'b1;
                    s1_q[c*N +: N]  <= D_IN1[c*N +: N];
                end else if (gnt_oh[c]) begin
                    v1_q[c] <= 1'b0;
                end
                if (cap2[c]) begin
                    v2_q[c]         <= 1'b1;
                    s2_q[c*N +: N]  <= D_IN2[c*N +: N];
                end else if (gnt_oh[c]) begin
                    v2_q[c] <= 1'b0;
                end
            end
            if (grant) ptr_q <= IW'((int'(gnt_idx) + 1) % NCH);
        end
    end

    // Tag pipeline mirrors the operator depth so each result knows its channel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < OP_LAT; i++) pipe_q[i] <= '0;
        end else if (EN) begin
            pipe_q[0] <= '{vld: grant, idx: TAG_IW'(gnt_idx)};
            for (int i = 1; i < OP_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tail = pipe_q[OP_LAT-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_q <= '0;
            d_out_q <= '0;
        end else begin
            r_out_q <= '0;
            if (EN && tail.vld && OP_R_IN) begin
                for (int c = 0; c < NCH; c++) begin
                    if (tail.idx == TAG_IW'(c)) begin
                        r_out_q[c]         <= 1'b1;
                        d_out_q[c*N +: N]  <= OP_D_IN;
                    end
                end
            end
        end
    end

    assign R_OUT = r_out_q;
    assign D_OUT = d_out_q;

`ifdef DF_OP_ARBITER_OVF_EN
    logic [NCH-1:0] ovf_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= '0;
        end else if (EN) begin
            ovf_q <= ovf_q | (R_IN1 & v1_q & ~gnt_oh) | (R_IN2 & v2_q & ~gnt_oh);
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = '0;
`endif

endmodule

// File: tb/tb_df_op_arbiter.sv
// Randomised and directed checks of df_op_arbiter against a per-channel slot/queue model.
// Operator stand-in is a one-cycle equality compare that can optionally drop its result.
module tb_df_op_arbiter;

    localparam int N   = 16;
    localparam int NCH = 4;
    localparam int LAT = 1;
`ifdef DF_OP_ARBITER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN  = 1'b0;
    logic [NCH-1:0]   R_IN1 = '0, R_IN2 = '0;
    logic [NCH*N-1:0] D_IN1 = '0, D_IN2 = '0;
    logic [NCH-1:0]   BUSY, R_OUT, OVF;
    logic             OP_R_OUT1, OP_R_OUT2, OP_EN, OP_R_IN;
    logic [N-1:0]     OP_D_OUT1, OP_D_OUT2, OP_D_IN;
    logic [NCH*N-1:0] D_OUT;

    logic             op_vld = 1'b0;
    logic [N-1:0]     op_dat = '0;
    logic             kill   = 1'b0;

    always #5 CLK = ~CLK;

    df_op_arbiter #(.N(N), .NCH(NCH), .OP_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .R_IN1(R_IN1), .R_IN2(R_IN2), .D_IN1(D_IN1), .D_IN2(D_IN2),
        .BUSY(BUSY),
        .OP_R_OUT1(OP_R_OUT1), .OP_R_OUT2(OP_R_OUT2),
        .OP_D_OUT1(OP_D_OUT1), .OP_D_OUT2(OP_D_OUT2),
        .OP_R_IN(OP_R_IN), .OP_D_IN(OP_D_IN), .OP_EN(OP_EN),
        .R_OUT(R_OUT), .D_OUT(D_OUT), .OVF(OVF)
    );

    // Shared operator: equality compare, one cycle, frozen by OP_EN.
    always @(posedge CLK) begin
        if (OP_EN) begin
            op_vld <= OP_R_OUT1 & OP_R_OUT2 & ~kill;
            op_dat <= (OP_D_OUT1 == OP_D_OUT2) ? 16'd1 : 16'd0;
        end
    end
    assign OP_R_IN = op_vld;
    assign OP_D_IN = op_dat;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model state
    bit          m_f1 [NCH], m_f2 [NCH];
    logic [15:0] m_v1 [NCH], m_v2 [NCH];
    logic [15:0] m_dout [NCH];
    logic [3:0]  m_rout, m_ovf;
    int          m_ptr;
    bit          q_vld [LAT], q_kill [LAT];
    int          q_ch [LAT];
    logic [15:0] q_val [LAT];

    // Staged stimulus, applied just after the falling edge
    bit               t_rst, t_en, t_kill;
    logic [NCH-1:0]   t_r1, t_r2;
    logic [NCH*N-1:0] t_d1, t_d2;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_f1[c] = 0; m_f2[c] = 0; m_v1[c] = '0; m_v2[c] = '0; m_dout[c] = '0;
        end
        for (int i = 0; i < LAT; i++) begin
            q_vld[i] = 0; q_kill[i] = 0; q_ch[i] = 0; q_val[i] = '0;
        end
        m_rout = '0; m_ovf = '0; m_ptr = 0;
    endtask

    task automatic idle();
        t_rst = 0; t_en = 1; t_kill = 0; t_r1 = '0; t_r2 = '0;
    endtask

    task automatic cycle();
        bit          found;
        int          g;
        logic [3:0]  busy;
        @(negedge CLK);
        busy = '0;
        for (int c = 0; c < NCH; c++) busy[c] = m_f1[c] | m_f2[c];
        chk("r_out", R_OUT, m_rout);
        for (int c = 0; c < NCH; c++) chk("d_out_lane", D_OUT[c*N +: N], m_dout[c]);
        chk("ovf", OVF, OVF_ON ? m_ovf : 4'h0);
        chk("busy", BUSY, busy);

        RST = t_rst; EN = t_en; kill = t_kill;
        R_IN1 = t_r1; R_IN2 = t_r2; D_IN1 = t_d1; D_IN2 = t_d2;
        #1;

        found = 0; g = 0;
        if (t_en) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_ptr + i) % NCH;
                if (!found && m_f1[c] && m_f2[c]) begin found = 1; g = c; end
            end
        end
        chk("op_r_out1", OP_R_OUT1, found);
        chk("op_r_out2", OP_R_OUT2, found);
        chk("op_d_out1", OP_D_OUT1, found ? m_v1[g] : 16'h0);
        chk("op_d_out2", OP_D_OUT2, found ? m_v2[g] : 16'h0);
        chk("op_en", OP_EN, t_en);

        if (t_rst) begin
            model_reset();
        end else if (t_en) begin
            m_rout = '0;
            if (q_vld[LAT-1] && !q_kill[LAT-1]) begin
                m_rout[q_ch[LAT-1]]  = 1'b1;
                m_dout[q_ch[LAT-1]]  = q_val[LAT-1];
            end
            for (int i = LAT - 1; i > 0; i--) begin
                q_vld[i] = q_vld[i-1]; q_kill[i] = q_kill[i-1];
                q_ch[i]  = q_ch[i-1];  q_val[i]  = q_val[i-1];
            end
            q_vld[0] = found; q_ch[0] = g; q_kill[0] = t_kill;
            q_val[0] = (found && m_v1[g] == m_v2[g]) ? 16'd1 : 16'd0;
            for (int c = 0; c < NCH; c++) begin
                bit gr;
                gr = found && (g == c);
                if (t_r1[c]) begin
                    if (!m_f1[c] || gr) begin m_f1[c] = 1; m_v1[c] = t_d1[c*N +: N]; end
                    else m_ovf[c] = 1'b1;
                end else if (gr) m_f1[c] = 0;
                if (t_r2[c]) begin
                    if (!m_f2[c] || gr) begin m_f2[c] = 1; m_v2[c] = t_d2[c*N +: N]; end
                    else m_ovf[c] = 1'b1;
                end else if (gr) m_f2[c] = 0;
            end
            if (found) m_ptr = (g + 1) % NCH;
        end else begin
            m_rout = '0;
        end
    endtask

    task automatic do_reset();
        idle(); t_rst = 1; cycle(); idle();
    endtask

    initial begin
        t_d1 = '0; t_d2 = '0;
        idle();
        RST = 1'b1; EN = 1'b0;
        repeat (2) @(posedge CLK);
        model_reset();
        cycle();

        // Single channel, operands arriving two cycles apart
        do_reset();
        t_r1 = 4'b0100; t_d1 = 64'd5 << 32; cycle();
        idle(); cycle();
        t_r2 = 4'b0100; t_d2 = 64'd5 << 32; cycle();
        idle(); cycle();
        chk("ch2_grant", OP_R_OUT1, 1'b1);
        chk("ch2_operand", OP_D_OUT1, 16'd5);
        cycle(); cycle();
        chk("ch2_result_pulse", R_OUT, 4'b0100);
        chk("ch2_result_data", D_OUT[47:32], 16'd1);

        // All four eligible together: grants rotate 0..3
        do_reset();
        t_r1 = 4'hF; t_r2 = 4'hF;
        t_d1 = {16'd103, 16'd102, 16'd101, 16'd100};
        t_d2 = {16'd103, 16'd102, 16'd101, 16'd100};
        cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_order_vld", OP_R_OUT1, 1'b1);
            chk("rr_order", OP_D_OUT1, 16'(100 + k));
        end
        repeat (3) cycle();

        // Second token into a full, ungranted slot is dropped
        do_reset();
        t_r1 = 4'b0010; t_d1 = 64'd7 << 16; cycle();
        t_d1 = 64'd9 << 16; cycle();
        idle(); cycle();
        chk("drop_busy", BUSY[1], 1'b1);
        chk("drop_ovf", OVF[1], OVF_ON);
        t_r2 = 4'b0010; t_d2 = 64'd7 << 16; cycle();
        idle(); cycle();
        chk("drop_kept_old", OP_D_OUT1, 16'd7);
        repeat (3) cycle();

        // Refill in the grant cycle
        do_reset();
        t_r1 = 4'b0001; t_r2 = 4'b0001; t_d1 = 64'd3; t_d2 = 64'd3; cycle();
        t_d1 = 64'd4; t_d2 = 64'd4; cycle();
        chk("refill_first", OP_D_OUT1, 16'd3);
        idle(); cycle();
        chk("refill_again", OP_R_OUT1, 1'b1);
        chk("refill_new", OP_D_OUT1, 16'd4);
        repeat (3) cycle();

        // EN low with a result in flight
        do_reset();
        t_r1 = 4'b1000; t_r2 = 4'b1000; t_d1 = 64'd6 << 48; t_d2 = 64'd6 << 48; cycle();
        idle(); cycle();
        chk("freeze_grant", OP_R_OUT1, 1'b1);
        t_en = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("freeze_no_rout", R_OUT, 4'h0);
        end
        idle(); cycle(); cycle();
        chk("freeze_resume_pulse", R_OUT, 4'b1000);
        chk("freeze_resume_data", D_OUT[63:48], 16'd1);

        // Reset right after a grant discards the in-flight result
        do_reset();
        t_r1 = 4'b0010; t_r2 = 4'b0010; t_d1 = 64'd2 << 16; t_d2 = 64'd2 << 16; cycle();
        idle(); cycle();
        t_rst = 1; cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rst_rout", R_OUT, 4'h0);
            chk("rst_dout", D_OUT, 64'h0);
            chk("rst_ovf", OVF, 4'h0);
            chk("rst_busy", BUSY, 4'h0);
            chk("rst_op_r", OP_R_OUT1, 1'b0);
        end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            t_rst  = ($urandom % 64) == 0;
            t_en   = ($urandom % 8) != 0;
            t_kill = ($urandom % 5) == 0;
            t_r1   = 4'($urandom);
            t_r2   = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                t_d1[c*N +: N] = 16'($urandom_range(0, 2));
                t_d2[c*N +: N] = 16'($urandom_range(0, 2));
            end
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
